// File: rtl/me_result_pkg.sv
// me_result_pkg: shared widths, frame length, FSM state type and index helper for the result link
package me_result_pkg;
  localparam int SAD_W = 14;
  localparam int MV_W = 5;
  localparam int IDX_OFF = 7;
  localparam int FRAME_LEN = 14;
  typedef enum logic {IDLE, SHIFT} rx_state_t;
  function automatic logic [3:0] mv2idx(input logic [MV_W-1:0] mv);
    return mv[3:0] + 4'(IDX_OFF);
  endfunction
endpackage

// File: rtl/ser2par_shift.sv
// ser2par_shift: MSB-first serial-to-parallel shift register with enable
// ports: clk, rst_n (async active-low), en, d (serial in), q (parallel out)
module ser2par_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= {q[WIDTH-2:0], d};
endmodule

// File: rtl/result_rx.sv
// result_rx: deserialises 14-bit-time result frames (SAD + MV X/Y) with optional best-SAD tracking
// ports: clk, rst_n (async active-low), frame_vld/sad_ser/x_ser/y_ser serial in, clr_best;
//        sad, mv_x, mv_y, idx_x, idx_y, out_valid, frame_err, best_sad, best_x, best_y out.
// config: define RESULT_RX_MIN_TRACK_EN to build the running-minimum tracker.
module result_rx
  import me_result_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_vld,
  input  logic             sad_ser,
  input  logic             x_ser,
  input  logic             y_ser,
  input  logic             clr_best,
  output logic [SAD_W-1:0] sad,
  output logic [MV_W-1:0]  mv_x,
  output logic [MV_W-1:0]  mv_y,
  output logic [3:0]       idx_x,
  output logic [3:0]       idx_y,
  output logic             out_valid,
  output logic             frame_err,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_x,
  output logic [MV_W-1:0]  best_y
);
  rx_state_t state;
  logic [3:0] cnt;
  logic [SAD_W-2:0] sad_sh;
  logic [MV_W-1:0] x_sh, y_sh;
  logic mv_en, last;
  logic [SAD_W-1:0] new_sad;
  // cnt is 0 in IDLE, so this also covers the first bit-time
  assign mv_en = frame_vld && cnt < 4'(MV_W);
  assign last = state == SHIFT && frame_vld && cnt == 4'(FRAME_LEN - 1);
  // the final SAD bit is taken straight from the line, not from the shifter
  assign new_sad = {sad_sh, sad_ser};
  ser2par_shift #(.WIDTH(SAD_W - 1)) u_sad (.clk, .rst_n, .en(frame_vld), .d(sad_ser), .q(sad_sh));
  ser2par_shift #(.WIDTH(MV_W)) u_x (.clk, .rst_n, .en(mv_en), .d(x_ser), .q(x_sh));
  ser2par_shift #(.WIDTH(MV_W)) u_y (.clk, .rst_n, .en(mv_en), .d(y_ser), .q(y_sh));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sad <= '0;
      mv_x <= '0;
      mv_y <= '0;
      idx_x <= '0;
      idx_y <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (frame_vld) begin
          state <= SHIFT;
          cnt <= 4'd1;
        end
        SHIFT: if (!frame_vld) begin
          state <= IDLE;
          cnt <= '0;
          frame_err <= 1'b1;
        end else if (last) begin
          state <= IDLE;
          cnt <= '0;
          sad <= new_sad;
          mv_x <= x_sh;
          mv_y <= y_sh;
          idx_x <= mv2idx(x_sh);
          idx_y <= mv2idx(y_sh);
          out_valid <= 1'b1;
        end else cnt <= cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
`ifdef RESULT_RX_MIN_TRACK_EN
  // strict compare keeps the earlier vector on ties; clear overrides an update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      best_sad <= '1;
      best_x <= '0;
      best_y <= '0;
    end else if (clr_best) begin
      best_sad <= '1;
      best_x <= '0;
      best_y <= '0;
    end else if (last && new_sad < best_sad) begin
      best_sad <= new_sad;
      best_x <= x_sh;
      best_y <= y_sh;
    end
`else
  logic unused_clr_best;
  assign unused_clr_best = clr_best;
  assign best_sad = '0;
  assign best_x = '0;
  assign best_y = '0;
`endif
endmodule

// File: tb/tb_result_rx.sv
// tb_result_rx: directed scoreboard bench for result_rx
`define CHK(t, o, e) begin total++; assert ((o) === (e)) else begin bad++; $error("FAIL %s: got %0h want %0h", t, (o), (e)); end end
module tb_result_rx;
  logic clk = 0, rst_n = 0, frame_vld = 0, sad_ser = 0, x_ser = 0, y_ser = 0, clr_best = 0;
  logic [13:0] sad, best_sad;
  logic [4:0] mv_x, mv_y, best_x, best_y;
  logic [3:0] idx_x, idx_y;
  logic out_valid, frame_err;
  int total = 0, bad = 0, cyc = 0, ov_n = 0, err_n = 0;
  int ov_t[$];
  typedef struct {logic [13:0] s; logic [4:0] x; logic [4:0] y;} exp_t;
  exp_t q[$];
`ifdef RESULT_RX_MIN_TRACK_EN
  localparam logic [13:0] BEST_RST = 14'h3FFF;
`else
  localparam logic [13:0] BEST_RST = 14'h0;
`endif
  result_rx dut (.clk(clk), .rst_n(rst_n), .frame_vld(frame_vld), .sad_ser(sad_ser), .x_ser(x_ser),
    .y_ser(y_ser), .clr_best(clr_best), .sad(sad), .mv_x(mv_x), .mv_y(mv_y), .idx_x(idx_x),
    .idx_y(idx_y), .out_valid(out_valid), .frame_err(frame_err), .best_sad(best_sad),
    .best_x(best_x), .best_y(best_y));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n) begin
    `CHK("excl", out_valid & frame_err, 1'b0)
    if (frame_err) err_n++;
    if (out_valid) begin
      ov_n++;
      ov_t.push_back(cyc);
      `CHK("spurious_ov", q.size() > 0, 1'b1)
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        `CHK("sad", sad, e.s)
        `CHK("mv_x", mv_x, e.x)
        `CHK("mv_y", mv_y, e.y)
        `CHK("idx_x", idx_x, 4'((e.x & 5'hF) + 7))
        `CHK("idx_y", idx_y, 4'((e.y & 5'hF) + 7))
      end
    end
  end
  task automatic drive_bits(input logic [13:0] s, input logic [4:0] x, input logic [4:0] y, input int n);
    logic [13:0] ss;
    logic [4:0] xs, ys;
    ss = s; xs = x; ys = y;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_vld = 1;
      sad_ser = ss[13];
      x_ser = i < 5 ? xs[4] : 1'($urandom);
      y_ser = i < 5 ? ys[4] : 1'($urandom);
      ss = ss << 1; xs = xs << 1; ys = ys << 1;
    end
  endtask
  task automatic send_frame(input logic [13:0] s, input logic [4:0] x, input logic [4:0] y);
    drive_bits(s, x, y, 14);
    q.push_back('{s, x, y});
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    frame_vld = 0;
    #1;
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    #1;
    `CHK("rst_sad", sad, 14'h0)
    `CHK("rst_mvx", mv_x, 5'h0)
    `CHK("rst_idx", {idx_x, idx_y}, 8'h0)
    `CHK("rst_flags", {out_valid, frame_err}, 2'b00)
    `CHK("rst_best", best_sad, BEST_RST)
    repeat (2) @(negedge clk);
    rst_n = 1;
    send_frame(14'h1234, 5'b11100, 5'b00011);
    @(negedge clk);
    frame_vld = 0;
    #1;
    `CHK("lat_ov", out_valid, 1'b1)
    `CHK("f1_idx_x", idx_x, 4'd3)
    `CHK("f1_idx_y", idx_y, 4'd10)
    idle(2);
    `CHK("hold_sad", sad, 14'h1234)
    send_frame(14'h0001, 5'b00101, 5'b11110);
    send_frame(14'h3FFF, 5'b11111, 5'b00111);
    idle(2);
    `CHK("b2b_cnt", ov_n, 3)
    `CHK("b2b_gap", ov_t[2] - ov_t[1], 14)
    drive_bits(14'h0ABC, 5'b01010, 5'b10101, 9);
    idle(3);
    `CHK("err_cnt", err_n, 1)
    `CHK("err_no_ov", ov_n, 3)
    `CHK("err_hold_sad", sad, 14'h3FFF)
    `CHK("err_hold_mv", {mv_x, mv_y}, 10'b11111_00111)
    send_frame(14'h2A5C, 5'b10110, 5'b01001);
    idle(2);
    `CHK("after_err_ov", ov_n, 4)
    drive_bits(14'h1111, 5'b00001, 5'b00010, 6);
    #2 rst_n = 0;
    #1;
    `CHK("mid_rst_sad", sad, 14'h0)
    `CHK("mid_rst_mv", {mv_x, mv_y, idx_x, idx_y}, 18'h0)
    `CHK("mid_rst_best", best_sad, BEST_RST)
    @(negedge clk);
    frame_vld = 0;
    rst_n = 1;
    send_frame(14'h0777, 5'b00110, 5'b11010);
    idle(2);
    `CHK("after_rst_ov", ov_n, 5)
    `CHK("after_rst_err", err_n, 1)
    send_frame(14'h0042, 5'b11000, 5'b00111);
    idle(1);
    `CHK("edge_idx_x", idx_x, 4'd15)
    `CHK("edge_idx_y", idx_y, 4'd14)
    @(negedge clk);
    clr_best = 1;
    @(negedge clk);
    clr_best = 0;
    #1;
    `CHK("clr_best", best_sad, BEST_RST)
    send_frame(14'd500, 5'b00001, 5'b00001);
    send_frame(14'd300, 5'b00010, 5'b00011);
    send_frame(14'd300, 5'b11101, 5'b11100);
    send_frame(14'd800, 5'b00100, 5'b00100);
    idle(2);
`ifdef RESULT_RX_MIN_TRACK_EN
    `CHK("best_sad", best_sad, 14'd300)
    `CHK("best_vec", {best_x, best_y}, 10'b00010_00011)
    @(negedge clk);
    clr_best = 1;
    @(negedge clk);
    clr_best = 0;
    #1;
    `CHK("best_clr", best_sad, 14'h3FFF)
    `CHK("best_clr_vec", {best_x, best_y}, 10'h0)
`else
    `CHK("best_tied", {best_sad, best_x, best_y}, 24'h0)
`endif
    `CHK("track_ov", ov_n, 10)
    `CHK("q_empty", q.size(), 0)
    `CHK("final_err", err_n, 1)
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_rx.md
RESULT_RX -- requirements
Module: result_rx

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 frame_vld  input  1  high for each serial bit-time of a result frame.
REQ-004 sad_ser  input  1  serial SAD bit, MSB first, 14 bit-times per frame.
REQ-005 x_ser  input  1  serial motion-vector X bit (5-bit two's complement), MSB first, valid in the first 5 bit-times of a frame.
REQ-006 y_ser  input  1  serial motion-vector Y bit, same timing as x_ser.
REQ-007 sad  output  14  received SAD.
REQ-008 mv_x, mv_y  output  5 each  received signed vectors, range -8..+7 meaningful.
REQ-009 idx_x, idx_y  output  4 each  search index, mv + 7, modulo 16.
REQ-010 out_valid  output  1  one-cycle pulse; sad/mv/idx are newly valid.
REQ-011 frame_err  output  1  one-cycle pulse; frame truncated.
REQ-012 clr_best  input  1  clears best tracker (MIN_TRACK_EN only).
REQ-013 best_sad 14, best_x 5, best_y 5  output  running minimum and its vector (MIN_TRACK_EN only).

Function
REQ-014 FSM states IDLE, SHIFT; 4-bit bit counter cnt.
- IDLE: frame_vld=1 -> sample bit 13 of SAD and bit 4 of X/Y; cnt=1; go to SHIFT.
- SHIFT: frame_vld=1 -> shift in the next bits; cnt+1.
REQ-015 X/Y are shifted only while cnt<5; bits on x_ser/y_ser in bit-times 5..13 are ignored.
REQ-016 When the 14th bit is sampled (cnt=13 in SHIFT):
- Load sad, mv_x, mv_y, idx_x, idx_y from the shift registers plus that bit on the next edge.
- Pulse out_valid on that same edge; latency is 1 cycle after the last bit.
- Return to IDLE.
REQ-017 Back-to-back frames: if frame_vld stays high after bit 14, the following bit-time is bit 13 of a new frame, with no gap cycle.
REQ-018 frame_vld=0 in SHIFT with cnt<14:
- Abort the frame; pulse frame_err for 1 cycle; return to IDLE.
- sad, mv_x, mv_y, idx_x, idx_y and out_valid are unchanged/low.
REQ-019 Output registers hold their values between frames; out_valid and frame_err are never high together.
REQ-020 idx computed as mv[3:0] + 4'd7, wrap modulo 16 (mv=-8 -> idx=15).

Reset
REQ-021 Asserting rst_n=0, including mid-frame, forces:
- FSM=IDLE, cnt=0, shift registers 0;
- sad=0, mv_x=0, mv_y=0, idx_x=0, idx_y=0;
- out_valid=0, frame_err=0;
- best_sad=14'h3FFF, best_x=0, best_y=0.
REQ-022 The first rising edge after deassertion with frame_vld=1 starts a frame.

Configuration
REQ-023 Macro RESULT_RX_MIN_TRACK_EN.
- Defined: on each out_valid, if sad < best_sad (strict), update best_sad/best_x/best_y on the same edge as out_valid.
- Ties keep the earlier vector.
- clr_best=1 sets best_sad=14'h3FFF, best_x/y=0; clr_best wins over a simultaneous update.
REQ-024 Undefined: clr_best is ignored; best_sad/best_x/best_y are tied to 0; no tracking logic is present.

Structure
REQ-025 Package me_result_pkg holds SAD_W=14, MV_W=5, IDX_OFF=7, FRAME_LEN=14 and the FSM state typedef; it is shared with the transmitter.
REQ-026 One sub-module, ser2par_shift (parameter width, MSB-first shift with enable), is instantiated three times: SAD, X, Y.

Verification
REQ-027 Frame sad=14'h1234, mv_x=5'b11100 (-4), mv_y=5'b00011 (+3) -> out_valid 1 cycle after bit 14; sad=14'h1234, idx_x=3, idx_y=10.
REQ-028 Two back-to-back frames (28 cycles of frame_vld, sad 14'h0001 then 14'h3FFF) -> two out_valid pulses 14 cycles apart with the correct values.
REQ-029 frame_vld drops after 9 bits -> frame_err pulse; no out_valid; outputs keep the prior frame's values; the next full frame decodes correctly.
REQ-030 rst_n pulsed low at bit 6 -> all outputs at reset values; the following full frame decodes correctly.
REQ-031 MIN_TRACK_EN: frames with sad 500, 300, 300 (second vector differs), 800 -> best_sad=300 with the first-300 vector; clr_best -> best_sad=14'h3FFF.
REQ-032 mv_x=-8 and mv_y=+7 -> idx_x=15, idx_y=14.
